// File: rtl/count_sweep_pkg.sv
// Shared types and default sizes for the count sweep controller.
package count_sweep_pkg;

   localparam int CS_WIDTH   = 32;
   localparam int CS_SWEEP_W = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      UP       = 3'd2,
      DOWN     = 3'd3,
      DWELL_HI = 3'd4,
      DWELL_LO = 3'd5
   } state_t;

endpackage

// File: rtl/count_sweep_dwell_timer.sv
// Dwell down-counter: loads LOAD_VAL, then counts down; o_expire marks the last dwell cycle.
// Only instantiated when COUNT_SWEEP_DWELL_EN is defined.
module count_sweep_dwell_timer #(
   parameter int CNT_W    = 3,
   parameter int LOAD_VAL = 4
) (
   input  logic clk,
   input  logic rst_s,
   input  logic i_load,
   output logic o_expire
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst_s)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= CNT_W'(LOAD_VAL);
      else if (r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   // A load value of 0 or 1 still gives a single dwell cycle.
   assign o_expire = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/count_sweep_ctrl.sv
// Drives an external up/down preloadable counter so its value sweeps lo..hi..lo.
// Optional dwell at each extreme is enabled by defining COUNT_SWEEP_DWELL_EN.
module count_sweep_ctrl
   import count_sweep_pkg::*;
#(
   parameter int WIDTH        = CS_WIDTH,
   parameter int SWEEP_W      = CS_SWEEP_W,
   parameter int DWELL_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_s,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   lo_bound,
   input  logic [WIDTH-1:0]   hi_bound,
   input  logic [SWEEP_W-1:0] num_sweeps,
   input  logic [WIDTH-1:0]   cnt_q,
   output logic [WIDTH-1:0]   din,
   output logic               preLoad,
   output logic               asc,
   output logic               busy,
   output logic               turn,
   output logic               done,
   output logic               err,
   output logic [SWEEP_W-1:0] sweep_cnt
);

   state_t             r_state;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_hi;
   logic [SWEEP_W-1:0] r_num;
   logic [SWEEP_W-1:0] r_sweep_cnt;
   logic               r_turn;
   logic               r_done;
   logic               r_err;

   logic               w_at_hi;
   logic               w_at_lo;
   logic [SWEEP_W-1:0] w_sweep_nxt;
   logic               w_last;
   state_t             w_after_up;
   state_t             w_after_down;

   // Turn one step early: the counter reaches the extreme on the same edge.
   assign w_at_hi     = (cnt_q >= r_hi - 1'b1);
   assign w_at_lo     = (cnt_q <= r_lo + 1'b1);
   assign w_sweep_nxt = r_sweep_cnt + 1'b1;
   assign w_last      = (r_num != '0) && (w_sweep_nxt == r_num);

`ifdef COUNT_SWEEP_DWELL_EN
   localparam int TW = (DWELL_CYCLES < 1) ? 1 : $clog2(DWELL_CYCLES + 1);

   logic w_dwell_load;
   logic w_dwell_exp;

   assign w_dwell_load = ((r_state == UP) && w_at_hi) ||
                         ((r_state == DOWN) && w_at_lo && !w_last);
   assign w_after_up   = DWELL_HI;
   assign w_after_down = DWELL_LO;

   count_sweep_dwell_timer #(
      .CNT_W    (TW),
      .LOAD_VAL (DWELL_CYCLES)
   ) u_dwell (
      .clk      (clk),
      .rst_s    (rst_s),
      .i_load   (w_dwell_load),
      .o_expire (w_dwell_exp)
   );
`else
   assign w_after_up   = DOWN;
   assign w_after_down = UP;
`endif

   always_ff @(posedge clk) begin
      if (rst_s) begin
         r_state     <= IDLE;
         r_lo        <= '0;
         r_hi        <= '0;
         r_num       <= '0;
         r_sweep_cnt <= '0;
         r_turn      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_turn <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (abort) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     if (lo_bound < hi_bound) begin
                        r_lo        <= lo_bound;
                        r_hi        <= hi_bound;
                        r_num       <= num_sweeps;
                        r_sweep_cnt <= '0;
                        r_state     <= LOAD;
                     end else begin
                        r_err <= 1'b1;
                     end
                  end
               end
               LOAD: r_state <= UP;
               UP: begin
                  if (w_at_hi) begin
                     r_turn  <= 1'b1;
                     r_state <= w_after_up;
                  end
               end
               DOWN: begin
                  if (w_at_lo) begin
                     r_sweep_cnt <= w_sweep_nxt;
                     if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                     end else begin
                        r_turn  <= 1'b1;
                        r_state <= w_after_down;
                     end
                  end
               end
`ifdef COUNT_SWEEP_DWELL_EN
               DWELL_HI: if (w_dwell_exp) r_state <= DOWN;
               DWELL_LO: if (w_dwell_exp) r_state <= UP;
`endif
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // Everything except UP/DOWN holds the counter by preloading it.
   always_comb begin
      preLoad = 1'b1;
      asc     = 1'b0;
      din     = cnt_q;
      case (r_state)
         LOAD: din = r_lo;
         UP: begin
            preLoad = 1'b0;
            asc     = 1'b1;
         end
         DOWN: preLoad = 1'b0;
         default: ;
      endcase
   end

   assign busy      = (r_state != IDLE);
   assign turn      = r_turn;
   assign done      = r_done;
   assign err       = r_err;
   assign sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Bench for count_sweep_ctrl with a preloadable up/down counter closed in the loop.
module tb_count_sweep_ctrl;

   localparam int W  = 32;
   localparam int SW = 8;
`ifdef COUNT_SWEEP_DWELL_EN
   localparam int DW = 2;
`else
   localparam int DW = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_s = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [W-1:0]  lo_bound = '0;
   logic [W-1:0]  hi_bound = '0;
   logic [SW-1:0] num_sweeps = '0;
   logic [W-1:0]  cnt = 32'd100;
   logic [W-1:0]  din;
   logic          preLoad, asc, busy, turn, done, err;
   logic [SW-1:0] sweep_cnt;

   int n_pass = 0;
   int n_chk  = 0;
   int n_fail = 0;

   int q_cnt[$];
   bit q_turn[$];
   bit q_done[$];
   int q_sw[$];

   count_sweep_ctrl #(
      .WIDTH        (W),
      .SWEEP_W      (SW),
      .DWELL_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst_s      (rst_s),
      .start      (start),
      .abort      (abort),
      .lo_bound   (lo_bound),
      .hi_bound   (hi_bound),
      .num_sweeps (num_sweeps),
      .cnt_q      (cnt),
      .din        (din),
      .preLoad    (preLoad),
      .asc        (asc),
      .busy       (busy),
      .turn       (turn),
      .done       (done),
      .err        (err),
      .sweep_cnt  (sweep_cnt)
   );

   always #5 clk = ~clk;

   // The counter being controlled.
   always @(posedge clk) begin
      if (preLoad)  cnt <= din;
      else if (asc) cnt <= cnt + 1;
      else          cnt <= cnt - 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int c, input bit t, input bit d, input int s);
      q_cnt.push_back(c);
      q_turn.push_back(t);
      q_done.push_back(d);
      q_sw.push_back(s);
   endtask

   // Expected counter trace, one entry per clock starting with the cycle lo appears.
   task automatic build(input int lo, input int hi, input int num, input int limit);
      int sw = 0;
      int s  = 0;
      bit last = 1'b0;
      q_cnt.delete(); q_turn.delete(); q_done.delete(); q_sw.delete();
      push(lo, 1'b0, 1'b0, 0);
      while (q_cnt.size() < limit) begin
         for (int v = lo + 1; v <= hi; v++) push(v, v == hi, 1'b0, sw);
         repeat (DW) push(hi, 1'b0, 1'b0, sw);
         s++;
         last = (num != 0) && (s == num);
         for (int v = hi - 1; v >= lo; v--) begin
            if (v == lo) sw = (sw + 1) % (1 << SW);
            push(v, (v == lo) && !last, (v == lo) && last, sw);
         end
         if (last) break;
         repeat (DW) push(lo, 1'b0, 1'b0, sw);
      end
   endtask

   task automatic run_sweep(input int lo, input int hi, input int num, input int limit,
                            input bit poke);
      int n;
      build(lo, hi, num, limit);
      n = (q_cnt.size() < limit) ? q_cnt.size() : limit;
      lo_bound = W'(lo); hi_bound = W'(hi); num_sweeps = SW'(num);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("load_busy", 32'(busy), 32'd1);
      chk("load_preload", 32'(preLoad), 32'd1);
      chk("load_din", din, 32'(lo));
      for (int i = 0; i < n; i++) begin
         lo_bound   = $urandom_range(0, 50);
         hi_bound   = $urandom_range(51, 100);
         num_sweeps = SW'($urandom);
         start      = poke && (i == 1 || i == 3);
         tick();
         start = 1'b0;
         chk("cnt", cnt, 32'(q_cnt[i]));
         chk("turn", 32'(turn), 32'(q_turn[i]));
         chk("done", 32'(done), 32'(q_done[i]));
         chk("sweep_cnt", 32'(sweep_cnt), 32'(q_sw[i]));
         chk("busy", 32'(busy), 32'(!q_done[i]));
         chk("err_run", 32'(err), 32'd0);
      end
      if (n == q_cnt.size() && q_done[n-1]) begin
         repeat (3) begin
            tick();
            chk("hold_cnt", cnt, 32'(lo));
            chk("hold_busy", 32'(busy), 32'd0);
            chk("hold_done", 32'(done), 32'd0);
         end
      end
   endtask

   initial begin
      logic [W-1:0] c;
      int lo, hi;

      tick();
      tick();
      chk("rst_preload", 32'(preLoad), 32'd1);
      chk("rst_asc", 32'(asc), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_turn", 32'(turn), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_sweep_cnt", 32'(sweep_cnt), 32'd0);
      rst_s = 1'b0;
      tick();
      chk("idle_hold", cnt, 32'd100);
      chk("idle_din", din, cnt);

      // Two full sweeps 3..6.
      run_sweep(3, 6, 2, 100000, 1'b0);

      // Rejected start with equal bounds, then with lo above hi.
      c = cnt;
      lo_bound = 5; hi_bound = 5; start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_eq", 32'(err), 32'd1);
      chk("err_eq_busy", 32'(busy), 32'd0);
      tick();
      chk("err_once", 32'(err), 32'd0);
      chk("err_hold", cnt, c);
      lo_bound = 9; hi_bound = 2; start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_gt", 32'(err), 32'd1);
      chk("err_gt_busy", 32'(busy), 32'd0);

      // Infinite 0..1 toggling, then abort.
      run_sweep(0, 1, 0, 11, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      c = cnt;
      chk("abort_step", 32'(c <= 32'd2), 32'd1);
      repeat (3) begin
         tick();
         chk("abort_hold", cnt, c);
         chk("abort_nodone", 32'(done), 32'd0);
      end

      // Sweep counter wraps after 256 sweeps in infinite mode.
      run_sweep(0, 1, 0, 2 * 257 + 1, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // Reset in the middle of a sweep.
      run_sweep(10, 20, 1, 6, 1'b0);
      rst_s = 1'b1;
      tick();
      rst_s = 1'b0;
      chk("mrst_preload", 32'(preLoad), 32'd1);
      chk("mrst_asc", 32'(asc), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_turn", 32'(turn), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_err", 32'(err), 32'd0);
      chk("mrst_sweep_cnt", 32'(sweep_cnt), 32'd0);
      c = cnt;
      tick();
      tick();
      chk("mrst_hold", cnt, c);

      // Repeated start and bound changes while busy are ignored.
      run_sweep(4, 9, 1, 100000, 1'b1);

      // start and abort together in IDLE.
      lo_bound = 1; hi_bound = 8; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", 32'(busy), 32'd0);
      chk("sa_err", 32'(err), 32'd0);
      tick();
      chk("sa_busy2", 32'(busy), 32'd0);

      // Short single sweep (dwells at each extreme when enabled).
      run_sweep(3, 5, 1, 100000, 1'b0);

      // Randomized sweeps.
      repeat (8) begin
         lo = $urandom_range(0, 200);
         hi = lo + $urandom_range(1, 6);
         run_sweep(lo, hi, $urandom_range(1, 3), 100000, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
